// File: rtl/mux2_stream_arbiter_if.sv
// mux2_stream_arbiter_if: two valid/ready requester streams muxed onto one
// output stream, plus the registered select and one-hot grant.
interface mux2_stream_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             in0_valid;
    logic             in1_valid;
    logic [WIDTH-1:0] in0_data;
    logic [WIDTH-1:0] in1_data;
    logic             in0_last;
    logic             in1_last;
    logic             in0_ready;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             sel;
    logic [1:0]       grant;

    modport master (
        output in0_valid, in1_valid, in0_data, in1_data, in0_last, in1_last, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_last, sel, grant
    );

    modport slave (
        input  in0_valid, in1_valid, in0_data, in1_data, in0_last, in1_last, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_last, sel, grant
    );
endinterface

// File: rtl/mux2_stream_arbiter.sv
// mux2_stream_arbiter: round-robin packet arbiter between two streams, holding
// ownership until last or MAX_BURST beats, with one idle cycle between grants.
module mux2_stream_arbiter #(
    parameter int WIDTH     = 64,
    parameter int MAX_BURST = 4
) (
    input logic                   clk,
    input logic                   reset_n,
    mux2_stream_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state_q;
    logic             sel_q;
    logic             prio_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [1:0]       grant_q;
    logic             own;
    logic             cur_valid;
    logic             cur_last;
    logic             xfer;
    logic             rel;
    logic [WIDTH-1:0] mux_data;

    // Data and handshake pass straight through from the owner; nothing is stored.
    assign own           = state_q != IDLE;
    assign cur_valid     = sel_q ? bus.in1_valid : bus.in0_valid;
    assign cur_last      = sel_q ? bus.in1_last : bus.in0_last;
    assign mux_data      = sel_q ? bus.in1_data : bus.in0_data;
    assign bus.out_data  = mux_data;
    assign bus.out_valid = own & cur_valid;
    assign bus.out_last  = own & cur_last;
    assign bus.in0_ready = (state_q == OWN0) & bus.out_ready;
    assign bus.in1_ready = (state_q == OWN1) & bus.out_ready;
    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign xfer          = bus.out_valid & bus.out_ready;
    assign cnt_d         = cnt_q + CW'(1);
    assign rel           = xfer & (cur_last | (cnt_d == MAX_CNT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b1;
            cnt_q   <= '0;
            grant_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    // On a tie the port that did not own last time wins.
                    if (bus.in0_valid && (!bus.in1_valid || prio_q)) begin
                        state_q <= OWN0;
                        sel_q   <= 1'b0;
                        grant_q <= 2'b01;
                    end else if (bus.in1_valid) begin
                        state_q <= OWN1;
                        sel_q   <= 1'b1;
                        grant_q <= 2'b10;
                    end
                end
                default: begin
                    if (rel) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                        prio_q  <= sel_q;
                        cnt_q   <= '0;
                    end else if (xfer) begin
                        cnt_q <= cnt_d;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// tb_mux2_stream_arbiter: directed scenarios for the two-port packet arbiter.
module tb_mux2_stream_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;

    mux2_stream_arbiter_if #(.WIDTH(64)) bus ();

    mux2_stream_arbiter #(.WIDTH(64), .MAX_BURST(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.in0_last = 1'b0;
        bus.in1_last = 1'b0;
        bus.in0_data = '0;
        bus.in1_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.grant !== 2'b00 || bus.sel !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.in0_ready !== 1'b0 || bus.in1_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_state grant=%b sel=%b ov=%b ol=%b rdy=%b%b want 00 0 0 0 00",
                     bus.grant, bus.sel, bus.out_valid, bus.out_last, bus.in1_ready, bus.in0_ready);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.in0_valid = 1'b1;
        bus.in0_last = 1'b1;
        bus.in0_data = 64'hA5;
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.grant !== 2'b00 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_pre grant=%b ov=%b want 00 0", bus.grant, bus.out_valid);
        end
        tick();
        total++;
        if (bus.grant !== 2'b01 || bus.sel !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 64'hA5 ||
            bus.out_last !== 1'b1 || bus.in0_ready !== 1'b1 || bus.in1_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_grant grant=%b sel=%b ov=%b data=%h ol=%b rdy=%b%b want 01 0 1 a5 1 01",
                     bus.grant, bus.sel, bus.out_valid, bus.out_data, bus.out_last, bus.in1_ready, bus.in0_ready);
        end
        tick();
        bus.in0_valid = 1'b0;
        #1;
        total++;
        if (bus.grant !== 2'b00 || bus.out_valid !== 1'b0 || bus.in0_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_release grant=%b ov=%b rdy0=%b want 00 0 0", bus.grant, bus.out_valid, bus.in0_ready);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g [6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        do_reset();
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        bus.in0_last = 1'b1;
        bus.in1_last = 1'b1;
        bus.in0_data = 64'h11;
        bus.in1_data = 64'h22;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (bus.grant !== exp_g[i]) begin
                bad++;
                $display("FAIL alternate_grant[%0d] got=%b want=%b", i, bus.grant, exp_g[i]);
            end
            if (exp_g[i] != 2'b00) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== (exp_g[i][1] ? 64'h22 : 64'h11)) begin
                    bad++;
                    $display("FAIL alternate_data[%0d] ov=%b data=%h", i, bus.out_valid, bus.out_data);
                end
            end
        end
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
    endtask

    task automatic test_burst();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in1_valid = 1'b1;
        bus.in1_last = 1'b0;
        bus.in1_data = 64'hB001;
        tick();
        bus.in0_valid = 1'b1;
        bus.in0_last = 1'b1;
        bus.in0_data = 64'hC0;
        #1;
        total++;
        if (bus.grant !== 2'b10 || bus.sel !== 1'b1 || bus.out_data !== 64'hB001 || bus.in1_ready !== 1'b1 ||
            bus.in0_ready !== 1'b0) begin
            bad++;
            $display("FAIL burst_b1 grant=%b sel=%b data=%h rdy=%b%b want 10 1 b001 10",
                     bus.grant, bus.sel, bus.out_data, bus.in1_ready, bus.in0_ready);
        end
        for (int b = 2; b <= 4; b++) begin
            tick();
            bus.in1_data = 64'hB000 + 64'(b);
            #1;
            total++;
            if (bus.grant !== 2'b10 || bus.out_valid !== 1'b1 || bus.out_data !== 64'hB000 + 64'(b)) begin
                bad++;
                $display("FAIL burst_b%0d grant=%b ov=%b data=%h want 10 1 %h",
                         b, bus.grant, bus.out_valid, bus.out_data, 64'hB000 + 64'(b));
            end
        end
        tick();
        bus.in1_data = 64'hB005;
        #1;
        total++;
        if (bus.grant !== 2'b00 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL burst_cap grant=%b ov=%b want 00 0", bus.grant, bus.out_valid);
        end
        tick();
        total++;
        if (bus.grant !== 2'b01 || bus.out_data !== 64'hC0 || bus.in1_ready !== 1'b0) begin
            bad++;
            $display("FAIL burst_in0 grant=%b data=%h rdy1=%b want 01 c0 0", bus.grant, bus.out_data, bus.in1_ready);
        end
        tick();
        bus.in0_valid = 1'b0;
        #1;
        total++;
        if (bus.grant !== 2'b00) begin
            bad++;
            $display("FAIL burst_gap2 grant=%b want 00", bus.grant);
        end
        tick();
        total++;
        if (bus.grant !== 2'b10 || bus.out_data !== 64'hB005 || bus.out_last !== 1'b0) begin
            bad++;
            $display("FAIL burst_b5 grant=%b data=%h ol=%b want 10 b005 0", bus.grant, bus.out_data, bus.out_last);
        end
        tick();
        bus.in1_data = 64'hB006;
        bus.in1_last = 1'b1;
        #1;
        total++;
        if (bus.grant !== 2'b10 || bus.out_data !== 64'hB006 || bus.out_last !== 1'b1) begin
            bad++;
            $display("FAIL burst_b6 grant=%b data=%h ol=%b want 10 b006 1", bus.grant, bus.out_data, bus.out_last);
        end
        tick();
        bus.in1_valid = 1'b0;
        #1;
        total++;
        if (bus.grant !== 2'b00) begin
            bad++;
            $display("FAIL burst_end grant=%b want 00", bus.grant);
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in0_valid = 1'b1;
        bus.in0_last = 1'b0;
        bus.in0_data = 64'hD1;
        tick();
        tick();
        bus.in0_data = 64'hD2;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.grant !== 2'b01 || bus.out_valid !== 1'b1 || bus.out_data !== 64'hD2 || bus.in0_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall[%0d] grant=%b ov=%b data=%h rdy0=%b want 01 1 d2 0",
                         i, bus.grant, bus.out_valid, bus.out_data, bus.in0_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in0_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_resume rdy0=%b want 1", bus.in0_ready);
        end
        tick();
        bus.in0_data = 64'hD3;
        tick();
        bus.in0_data = 64'hD4;
        #1;
        total++;
        if (bus.grant !== 2'b01 || bus.out_data !== 64'hD4) begin
            bad++;
            $display("FAIL stall_b4 grant=%b data=%h want 01 d4", bus.grant, bus.out_data);
        end
        tick();
        bus.in0_valid = 1'b0;
        #1;
        total++;
        if (bus.grant !== 2'b00) begin
            bad++;
            $display("FAIL stall_cap grant=%b want 00", bus.grant);
        end
    endtask

    task automatic test_gap();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        bus.in0_last = 1'b0;
        bus.in1_last = 1'b1;
        bus.in0_data = 64'hE1;
        bus.in1_data = 64'hF1;
        tick();
        tick();
        bus.in0_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (bus.grant !== 2'b01 || bus.out_valid !== 1'b0 || bus.in1_ready !== 1'b0) begin
                bad++;
                $display("FAIL gap[%0d] grant=%b ov=%b rdy1=%b want 01 0 0", i, bus.grant, bus.out_valid, bus.in1_ready);
            end
            tick();
        end
        bus.in0_valid = 1'b1;
        bus.in0_last = 1'b1;
        bus.in0_data = 64'hE2;
        #1;
        total++;
        if (bus.grant !== 2'b01 || bus.out_valid !== 1'b1 || bus.out_data !== 64'hE2) begin
            bad++;
            $display("FAIL gap_resume grant=%b ov=%b data=%h want 01 1 e2", bus.grant, bus.out_valid, bus.out_data);
        end
        tick();
        bus.in0_valid = 1'b0;
        #1;
        total++;
        if (bus.grant !== 2'b00) begin
            bad++;
            $display("FAIL gap_release grant=%b want 00", bus.grant);
        end
        tick();
        total++;
        if (bus.grant !== 2'b10 || bus.out_data !== 64'hF1) begin
            bad++;
            $display("FAIL gap_switch grant=%b data=%h want 10 f1", bus.grant, bus.out_data);
        end
        bus.in1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b1;
        bus.in1_valid = 1'b1;
        bus.in1_last = 1'b0;
        bus.in1_data = 64'h71;
        tick();
        bus.in0_valid = 1'b1;
        bus.in0_data = 64'h81;
        bus.in0_last = 1'b1;
        tick();
        bus.in1_data = 64'h72;
        #1;
        total++;
        if (bus.grant !== 2'b10 || bus.sel !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre grant=%b sel=%b want 10 1", bus.grant, bus.sel);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (bus.grant !== 2'b00 || bus.sel !== 1'b0 || bus.out_valid !== 1'b0 || bus.in0_ready !== 1'b0 ||
            bus.in1_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async grant=%b sel=%b ov=%b rdy=%b%b want 00 0 0 00",
                     bus.grant, bus.sel, bus.out_valid, bus.in1_ready, bus.in0_ready);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        total++;
        if (bus.grant !== 2'b01 || bus.out_data !== 64'h81) begin
            bad++;
            $display("FAIL midrst_tie grant=%b data=%h want 01 81", bus.grant, bus.out_data);
        end
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_burst();
        test_stall();
        test_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
